// File: rtl/fp_norm_seq.sv
// Post-add normalization sequencer: finds the leading one a nibble per cycle,
// then shifts the mantissa and adjusts the exponent in a single cycle.
module fp_norm_seq #(
  parameter int DATA_W = 28,
  parameter int EXP_W  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_W-1:0]          i_mant,
  input  logic [EXP_W-1:0]           i_exp,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_W-1:0]          o_mant,
  output logic [EXP_W-1:0]           o_exp,
  output logic [$clog2(DATA_W):0]    o_lz,
  output logic                       o_zero,
  output logic                       o_underflow,
  output logic [1:0]                 o_state
);

  // Handshake: an operand transfers on a rising edge with i_valid && o_ready;
  // a result transfers on a rising edge with o_valid && i_ready. o_valid holds
  // with stable data until accepted; i_flush overrides both handshakes.

  localparam int NIB  = DATA_W / 4;
  localparam int KW   = $clog2(NIB);
  localparam int LZ_W = $clog2(DATA_W) + 1;
  localparam int CW   = (LZ_W > EXP_W) ? LZ_W : EXP_W;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mant_q;
  logic [EXP_W-1:0]  exp_q;
  logic [KW-1:0]     k_q;
  logic [LZ_W-1:0]   lz_q;
  logic              zero_q;

  logic [3:0]        nib;
  logic [1:0]        pos;
  logic              nib_zero;
  logic [LZ_W-1:0]   lz_found;
  logic [CW-1:0]     lz_ext;
  logic [CW-1:0]     exp_ext;
  logic [CW-1:0]     exp_diff;

  // Shared 4-bit leading-one detector fed by the nibble selected by k_q.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (k_q == KW'(i)) nib = mant_q[DATA_W-1-4*i -: 4];
    end
    nib_zero = (nib == 4'b0000);
    casez (nib)
      4'b1???: pos = 2'd3;
      4'b01??: pos = 2'd2;
      4'b001?: pos = 2'd1;
      default: pos = 2'd0;
    endcase
    // 4*k + (3-p) is simply {k, ~p}.
    lz_found = LZ_W'({k_q, ~pos});
    lz_ext   = CW'(lz_q);
    exp_ext  = CW'(exp_q);
    exp_diff = exp_ext - lz_ext;
  end

  assign o_ready = (state == IDLE);
  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      k_q         <= '0;
      lz_q        <= '0;
      zero_q      <= 1'b0;
      o_valid     <= 1'b0;
      o_mant      <= '0;
      o_exp       <= '0;
      o_lz        <= '0;
      o_zero      <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_flush) begin
      state       <= IDLE;
      k_q         <= '0;
      zero_q      <= 1'b0;
      o_valid     <= 1'b0;
      o_mant      <= '0;
      o_exp       <= '0;
      o_lz        <= '0;
      o_zero      <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            mant_q <= i_mant;
            exp_q  <= i_exp;
            k_q    <= '0;
            zero_q <= 1'b0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (!nib_zero) begin
            lz_q  <= lz_found;
            state <= SHIFT;
          end else if (k_q == KW'(NIB-1)) begin
            zero_q <= 1'b1;
            lz_q   <= '0;
            state  <= SHIFT;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        SHIFT: begin
          o_valid <= 1'b1;
          state   <= DONE;
          if (zero_q) begin
            o_mant      <= '0;
            o_exp       <= '0;
            o_lz        <= '0;
            o_zero      <= 1'b1;
            o_underflow <= 1'b0;
          end else if (lz_ext <= exp_ext) begin
            o_mant      <= mant_q << lz_q;
            o_exp       <= exp_diff[EXP_W-1:0];
            o_lz        <= lz_q;
            o_zero      <= 1'b0;
            o_underflow <= 1'b0;
          end else begin
            // Exponent smaller than lz here, so it fits the shift width.
            o_mant      <= mant_q << exp_ext[LZ_W-1:0];
            o_exp       <= '0;
            o_lz        <= exp_ext[LZ_W-1:0];
            o_zero      <= 1'b0;
            o_underflow <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid     <= 1'b0;
            o_mant      <= '0;
            o_exp       <= '0;
            o_lz        <= '0;
            o_zero      <= 1'b0;
            o_underflow <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_seq.sv
// Directed plus random bench for fp_norm_seq; expected results come from a
// leading-zero model and are queued at accept time, popped at o_valid.
module tb_fp_norm_seq;

  localparam int DATA_W = 28;
  localparam int EXP_W  = 8;
  localparam int NIB    = DATA_W / 4;
  localparam int LZ_W   = $clog2(DATA_W) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [LZ_W-1:0]   lz;
    logic              zero;
    logic              uf;
    logic [7:0]        lat;
  } exp_t;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_mant;
  logic [EXP_W-1:0]  i_exp;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_mant;
  logic [EXP_W-1:0]  o_exp;
  logic [LZ_W-1:0]   o_lz;
  logic              o_zero;
  logic              o_underflow;
  logic [1:0]        o_state;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  fp_norm_seq #(.DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mant(i_mant), .i_exp(i_exp), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_mant(o_mant), .o_exp(o_exp), .o_lz(o_lz),
    .o_zero(o_zero), .o_underflow(o_underflow), .o_state(o_state)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic exp_t model(input logic [DATA_W-1:0] m, input logic [EXP_W-1:0] e);
    exp_t r;
    int   lz;
    r  = '0;
    lz = 0;
    if (m == '0) begin
      r.zero = 1'b1;
      r.lat  = 8'(NIB + 1);
      return r;
    end
    while (!m[DATA_W-1-lz]) lz++;
    r.lat = 8'(lz / 4 + 2);
    if (lz <= int'(e)) begin
      r.mant = m << lz;
      r.exp  = 8'(int'(e) - lz);
      r.lz   = LZ_W'(lz);
    end else begin
      r.mant = m << e;
      r.exp  = '0;
      r.lz   = LZ_W'(e);
      r.uf   = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all drive and sample happens on the falling edge.
  task automatic send(input logic [DATA_W-1:0] m, input logic [EXP_W-1:0] e);
    check("ready_before_accept", 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_mant  = m;
    i_exp   = e;
    exp_q.push_back(model(m, e));
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_result();
    int   lat;
    exp_t x;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    check("result_valid", 32'(o_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check("latency", 32'(lat), 32'(x.lat));
      check("mant", 32'(o_mant), 32'(x.mant));
      check("exp", 32'(o_exp), 32'(x.exp));
      check("lz", 32'(o_lz), 32'(x.lz));
      check("zero", 32'(o_zero), 32'(x.zero));
      check("underflow", 32'(o_underflow), 32'(x.uf));
      check("ready_in_done", 32'(o_ready), 32'd0);
    end
  endtask

  task automatic handshake();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("hs_valid_drop", 32'(o_valid), 32'd0);
    check("hs_ready_rise", 32'(o_ready), 32'd1);
    check("hs_flags_clear", {o_lz, o_zero, o_underflow}, 32'd0);
  endtask

  task automatic run_op(input logic [DATA_W-1:0] m, input logic [EXP_W-1:0] e);
    send(m, e);
    wait_result();
    handshake();
  endtask

  initial begin
    logic [DATA_W-1:0] held_mant;
    logic [EXP_W-1:0]  held_exp;
    logic [LZ_W-1:0]   held_lz;
    int                seen;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_mant  = '0;
    i_exp   = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_outs", 32'(o_mant) | 32'(o_exp) | 32'(o_lz) | 32'(o_zero) | 32'(o_underflow), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Directed plan points
    run_op(28'h8000000, 8'd10);
    run_op(28'h0000123, 8'd30);
    run_op(28'h0000000, 8'd50);
    run_op(28'h0000123, 8'd5);
    run_op(28'h0000001, 8'd27);
    run_op(28'h0000001, 8'd26);

    // Backpressure on the mid-nibble operand
    send(28'h0000123, 8'd30);
    wait_result();
    held_mant = o_mant;
    held_exp  = o_exp;
    held_lz   = o_lz;
    repeat (3) begin
      @(negedge i_clk);
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_mant", 32'(o_mant), 32'(held_mant));
      check("bp_exp", 32'(o_exp), 32'(held_exp));
      check("bp_lz", 32'(o_lz), 32'(held_lz));
    end
    handshake();
    run_op(28'h4000000, 8'd3);

    // Flush during SCAN
    send(28'h0000001, 8'd40);
    repeat (2) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush_idle", 32'(o_ready), 32'd1);
    exp_q.delete();
    seen = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush in IDLE beats i_valid
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_mant  = 28'h0000010;
    @(negedge i_clk);
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_no_accept", 32'(o_ready), 32'd1);

    // Asynchronous reset mid-SCAN
    send(28'h0000001, 8'd40);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_scan_ready", 32'(o_ready), 32'd1);
    check("arst_scan_valid", 32'(o_valid), 32'd0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("arst_scan_no_valid", 32'(o_valid), 32'd0);
    run_op(28'h4000000, 8'd3);

    // Asynchronous reset while a result is held
    send(28'h0000123, 8'd30);
    wait_result();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_done_valid", 32'(o_valid), 32'd0);
    check("arst_done_ready", 32'(o_ready), 32'd1);
    check("arst_done_outs", 32'(o_mant) | 32'(o_exp) | 32'(o_lz) | 32'(o_zero) | 32'(o_underflow), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Random operands
    for (int i = 0; i < 10; i++) begin
      run_op(DATA_W'($urandom) >> $urandom_range(0, DATA_W - 1), EXP_W'($urandom_range(0, 40)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
